// File: rtl/rat_reduce.sv
// Rational normalizer: reduces num/den to lowest terms using a binary (Stein) GCD
// followed by a restoring division of |num| and den by the shared GCD.
module rat_reduce #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_num,
    input  logic [WIDTH-1:0] i_in_den,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_num,
    output logic [WIDTH-1:0] o_out_den,
    output logic             o_out_err
);

    // state  | meaning
    // IDLE   | waiting for an input fraction
    // CHECK  | zero numerator / zero denominator short-cuts
    // GCD    | one Stein step per cycle
    // DIV    | WIDTH cycles of shared-divisor restoring division
    // DONE   | result held until the consumer takes it
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_GCD, S_DIV, S_DONE} state_t;

    localparam int KW = $clog2(WIDTH) + 1;
    localparam int SW = $clog2(2 * WIDTH) + 1;

    state_t           r_state;
    state_t           w_next;
    logic             r_sign;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic [SW-1:0]    r_steps;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_qn;
    logic [WIDTH-1:0] r_qd;
    logic [WIDTH-1:0] r_rn;
    logic [WIDTH-1:0] r_rd;
    logic [KW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out_num;
    logic [WIDTH-1:0] r_out_den;
    logic             r_out_err;

    logic [WIDTH-1:0] w_abs;
    logic             w_a_eq_b;
    logic             w_timeout;
    logic             w_div_last;
    logic [WIDTH-1:0] w_rn_low;
    logic [WIDTH-1:0] w_rd_low;
    logic             w_rn_ge;
    logic             w_rd_ge;
    logic [WIDTH-1:0] w_rn_nx;
    logic [WIDTH-1:0] w_rd_nx;
    logic [WIDTH-1:0] w_qn_nx;
    logic [WIDTH-1:0] w_qd_nx;

    assign w_abs      = i_in_num[WIDTH-1] ? (~i_in_num + WIDTH'(1)) : i_in_num;
    assign w_a_eq_b   = (r_a == r_b);
    assign w_timeout  = (r_steps == SW'(2 * WIDTH));
    assign w_div_last = (r_cnt == KW'(WIDTH - 1));

    // Shifted remainder is WIDTH+1 bits; its top bit is carried separately so the
    // subtraction stays WIDTH wide (the true difference is always below g).
    assign w_rn_low = {r_rn[WIDTH-2:0], r_qn[WIDTH-1]};
    assign w_rd_low = {r_rd[WIDTH-2:0], r_qd[WIDTH-1]};
    assign w_rn_ge  = r_rn[WIDTH-1] | (w_rn_low >= r_g);
    assign w_rd_ge  = r_rd[WIDTH-1] | (w_rd_low >= r_g);
    assign w_rn_nx  = w_rn_ge ? (w_rn_low - r_g) : w_rn_low;
    assign w_rd_nx  = w_rd_ge ? (w_rd_low - r_g) : w_rd_low;
    assign w_qn_nx  = {r_qn[WIDTH-2:0], w_rn_ge};
    assign w_qd_nx  = {r_qd[WIDTH-2:0], w_rd_ge};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_in_valid) w_next = S_CHECK;
            S_CHECK: w_next = (r_b == '0 || r_a == '0) ? S_DONE : S_GCD;
            S_GCD:   if (w_a_eq_b || w_timeout) w_next = S_DIV;
            S_DIV:   if (w_div_last) w_next = S_DONE;
            S_DONE:  if (i_out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sign    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_k       <= '0;
            r_steps   <= '0;
            r_g       <= '0;
            r_qn      <= '0;
            r_qd      <= '0;
            r_rn      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_out_num <= '0;
            r_out_den <= '0;
            r_out_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_sign  <= i_in_num[WIDTH-1];
                        r_a     <= w_abs;
                        r_b     <= i_in_den;
                        r_k     <= '0;
                        r_steps <= '0;
                        r_qn    <= w_abs;
                        r_qd    <= i_in_den;
                        r_rn    <= '0;
                        r_rd    <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_CHECK: begin
                    if (r_b == '0) begin
                        r_out_num <= '0;
                        r_out_den <= '0;
                        r_out_err <= 1'b1;
                    end else if (r_a == '0) begin
                        r_out_num <= '0;
                        r_out_den <= WIDTH'(1);
                        r_out_err <= 1'b0;
                    end
                end
                S_GCD: begin
                    r_steps <= r_steps + SW'(1);
                    if (w_a_eq_b) begin
                        r_g <= r_a << r_k;
                    end else if (w_timeout) begin
                        // 2^k always divides both operands, so the result stays exact.
                        r_g <= WIDTH'(1) << r_k;
                    end else if (!r_a[0] && !r_b[0]) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + KW'(1);
                    end else if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                    end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                    end else if (r_a > r_b) begin
                        r_a <= r_a - r_b;
                    end else begin
                        r_b <= r_b - r_a;
                    end
                end
                S_DIV: begin
                    r_qn  <= w_qn_nx;
                    r_qd  <= w_qd_nx;
                    r_rn  <= w_rn_nx;
                    r_rd  <= w_rd_nx;
                    r_cnt <= r_cnt + KW'(1);
                    if (w_div_last) begin
                        assert (w_rn_nx == '0 && w_rd_nx == '0);
                        r_out_num <= r_sign ? (~w_qn_nx + WIDTH'(1)) : w_qn_nx;
                        r_out_den <= w_qd_nx;
                        r_out_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_out_num   = r_out_num;
    assign o_out_den   = r_out_den;
    assign o_out_err   = r_out_err;

endmodule
